// File: rtl/weight_db_reader.sv
// Read-side controller for the weight double buffer: swaps banks with the writer,
// then streams each tile (optionally replayed) through a 2-entry output FIFO.
module weight_db_reader #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 10,
    parameter int BANK_DEPTH      = 288
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_tile_done,
    output logic                       wr_bank_free,
    input  logic [7:0]                 reuse_cnt,
    output logic                       switch_banks,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] radr,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       overflow
);

    typedef enum logic [1:0] {IDLE, SWITCH, READ, DRAIN} state_t;

    localparam logic [BANK_ADDR_WIDTH-1:0] LAST_ADR = BANK_ADDR_WIDTH'(BANK_DEPTH - 1);

    state_t                state;
    state_t                next_state;
    logic                  wr_full;
    logic                  tile_pending;
    logic                  rd_valid;
    logic                  done_issue;
    logic [7:0]            passes;
    logic [7:0]            pass_cnt;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [1:0]            count_next;
    logic                  from_fifo;
    logic                  pop;
    logic                  store;

    // A pulse arriving this cycle counts as pending so an idle reader switches next cycle.
    assign tile_pending = wr_full || wr_tile_done;
    assign wr_bank_free = !wr_full;
    assign busy         = (state != IDLE) || out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (tile_pending) next_state = SWITCH;
            SWITCH: next_state = READ;
            READ: begin
                // done_issue is only seen in READ in the cycle the final read returns
                if (done_issue) begin
                    if (tile_pending)           next_state = SWITCH;
                    else if (count_next != 2'd0) next_state = DRAIN;
                    else                        next_state = IDLE;
                end
            end
            DRAIN: begin
                if (tile_pending)            next_state = SWITCH;
                else if (count_next == 2'd0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        switch_banks = (state == SWITCH);
        ren          = (state == READ) && !done_issue &&
                       (({1'b0, count} + {2'b00, rd_valid}) < 3'd2);
    end

    // Clear-then-set ordering lets a pulse in the switch cycle re-arm without overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_full  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == SWITCH) wr_full <= 1'b0;
            if (wr_tile_done) begin
                if (wr_full && (state != SWITCH)) overflow <= 1'b1;
                else                              wr_full  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            radr       <= '0;
            pass_cnt   <= 8'd0;
            passes     <= 8'd1;
            done_issue <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= ren;
            if (state == SWITCH) begin
                radr       <= '0;
                pass_cnt   <= 8'd0;
                done_issue <= 1'b0;
                passes     <= (reuse_cnt == 8'd0) ? 8'd1 : reuse_cnt;
            end else if (ren) begin
                if (radr == LAST_ADR) begin
                    radr <= '0;
                    if (pass_cnt == passes - 8'd1) done_issue <= 1'b1;
                    else                           pass_cnt   <= pass_cnt + 8'd1;
                end else begin
                    radr <= radr + BANK_ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Returning data bypasses an empty FIFO so it is visible in its return cycle.
    always_comb begin
        from_fifo = (count != 2'd0);
        out_valid = from_fifo || rd_valid;
        if (from_fifo)     out_data = fifo_mem[rd_ptr];
        else if (rd_valid) out_data = rdata;
        else               out_data = '0;
        pop        = out_valid && out_ready;
        store      = rd_valid && (from_fifo || !pop);
        count_next = count + {1'b0, store} - {1'b0, pop && from_fifo};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count_next;
            if (store)             wr_ptr <= !wr_ptr;
            if (pop && from_fifo)  rd_ptr <= !rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (store) fifo_mem[wr_ptr] <= rdata;
    end

endmodule

// File: tb/tb_weight_db_reader.sv
// Bench for weight_db_reader: buffer model, behavioural stream/flag model,
// directed timing scenarios plus randomized tiles and backpressure.
module tb_weight_db_reader;

    localparam int DW    = 64;
    localparam int AW    = 10;
    localparam int DEPTH = 288;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_tile_done = 1'b0;
    logic          wr_bank_free;
    logic [7:0]    reuse_cnt = 8'd1;
    logic          switch_banks;
    logic          ren;
    logic [AW-1:0] radr;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          overflow;

    weight_db_reader #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .BANK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_tile_done(wr_tile_done), .wr_bank_free(wr_bank_free),
        .reuse_cnt(reuse_cnt), .switch_banks(switch_banks), .ren(ren), .radr(radr),
        .rdata(rdata), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: each bank word is base + address; a switch hands the written bank to the reader.
    logic [DW-1:0] write_base = '0;
    logic [DW-1:0] read_base = '0;
    always @(posedge clk) begin
        if (switch_banks) read_base <= write_base;
        if (ren) rdata <= read_base + DW'(radr);
    end

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend_q[$];
    logic          model_full = 1'b0;
    logic          ovf_exp = 1'b0;
    logic          mon_en = 1'b0;
    logic          bp_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int issued = 0, popped = 0, rd_idx = 0, cur_total = 0, last_ren_cyc = -10;
    int sw_cyc_q[$];
    int sw_ren_q[$];
    int first_ren_cyc = -1, first_ren_adr = -1, first_valid_cyc = -1, last_valid_cyc = -1;
    int last_busy_cyc = -1, max_gap = 0, xfer_cnt = 0, pulse_cyc = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: every tile is passes x (base + 0..DEPTH-1); flags follow the pulse/switch rules.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("bank_free", 64'(wr_bank_free), 64'(!model_full));
            checkOutput("overflow", 64'(overflow), 64'(ovf_exp));
            if (busy) last_busy_cyc = cyc;
            if (ren) begin
                checkOutput("ren_budget", 64'((issued - popped) < 2), 64'(1));
                checkOutput("radr", 64'(radr), 64'(rd_idx % DEPTH));
                checkOutput("ren_in_tile", 64'(rd_idx < cur_total), 64'(1));
                if (first_ren_cyc < 0) begin
                    first_ren_cyc = cyc;
                    first_ren_adr = int'(radr);
                end
                last_ren_cyc = cyc;
                issued++;
                rd_idx++;
            end
            if (prev_stall) begin
                checkOutput("stall_valid", 64'(out_valid), 64'(1));
                checkOutput("stall_data", out_data, prev_data);
            end
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (last_valid_cyc >= 0 && (cyc - last_valid_cyc - 1) > max_gap)
                    max_gap = cyc - last_valid_cyc - 1;
                last_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                checkOutput("word_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) checkOutput("out_data", out_data, exp_q.pop_front());
                popped++;
                xfer_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (switch_banks) begin
                int np;
                logic [DW-1:0] b;
                checkOutput("switch_pending", 64'(pend_q.size() != 0), 64'(1));
                checkOutput("switch_after_reads", 64'(rd_idx == cur_total), 64'(1));
                checkOutput("switch_after_return", 64'(last_ren_cyc < cyc - 1), 64'(1));
                sw_cyc_q.push_back(cyc);
                sw_ren_q.push_back(last_ren_cyc);
                np = (reuse_cnt == 8'd0) ? 1 : int'(reuse_cnt);
                b  = (pend_q.size() != 0) ? pend_q.pop_front() : '0;
                for (int p = 0; p < np; p++)
                    for (int a = 0; a < DEPTH; a++) exp_q.push_back(b + DW'(a));
                cur_total  = np * DEPTH;
                rd_idx     = 0;
                model_full = 1'b0;
            end
            if (wr_tile_done) begin
                if (model_full) ovf_exp = 1'b1;
                else begin
                    model_full = 1'b1;
                    pend_q.push_back(write_base);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #700000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        exp_q.delete();
        pend_q.delete();
        model_full = 1'b0;
        ovf_exp = 1'b0;
        issued = 0;
        popped = 0;
        rd_idx = 0;
        cur_total = 0;
        prev_stall = 1'b0;
        last_ren_cyc = -10;
    endtask

    task automatic clearMarks();
        sw_cyc_q.delete();
        sw_ren_q.delete();
        first_ren_cyc = -1;
        first_ren_adr = -1;
        first_valid_cyc = -1;
        last_valid_cyc = -1;
        last_busy_cyc = -1;
        max_gap = 0;
        xfer_cnt = 0;
    endtask

    // The writer only refills its bank when the reader reports it free.
    task automatic applyStimulus(input logic [DW-1:0] base, input logic [7:0] reuse);
        if (wr_bank_free) write_base = base;
        reuse_cnt    = reuse;
        wr_tile_done = 1'b1;
        pulse_cyc    = cyc;
        @(posedge clk);
        #1;
        wr_tile_done = 1'b0;
    endtask

    task automatic waitIdle();
        int i;
        for (i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (!busy && exp_q.size() == 0 && pend_q.size() == 0) break;
        end
        checkOutput("idle_reached", 64'(i < 20000), 64'(1));
        waitCycles(1);
    endtask

    task automatic waitWords(input int n);
        for (int i = 0; i < 5000 && xfer_cnt < n; i++) @(negedge clk);
        checkOutput("wait_words", 64'(xfer_cnt >= n), 64'(1));
        waitCycles(1);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_switch_banks", 64'(switch_banks), 64'(0));
        checkOutput("rst_ren", 64'(ren), 64'(0));
        checkOutput("rst_radr", 64'(radr), 64'(0));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", out_data, 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_bank_free", 64'(wr_bank_free), 64'(1));
    endtask

    task automatic doReset();
        rst = 1'b1;
        mon_en = 1'b0;
        waitCycles(1);
        checkResetValues();
        rst = 1'b0;
        clearModel();
        clearMarks();
        mon_en = 1'b1;
    endtask

    initial begin
        int t;
        waitCycles(2);
        doReset();

        $display("[TB] single tile");
        applyStimulus('0, 8'd1);
        t = pulse_cyc;
        waitIdle();
        checkOutput("t1_sw_count", 64'(sw_cyc_q.size()), 64'(1));
        checkOutput("t1_sw_cycle", 64'(sw_cyc_q[0]), 64'(t + 1));
        checkOutput("t1_first_ren", 64'(first_ren_cyc), 64'(t + 2));
        checkOutput("t1_first_radr", 64'(first_ren_adr), 64'(0));
        checkOutput("t1_first_valid", 64'(first_valid_cyc), 64'(t + 3));
        checkOutput("t1_last_valid", 64'(last_valid_cyc), 64'(t + 2 + DEPTH));
        checkOutput("t1_busy_fall", 64'(last_busy_cyc), 64'(t + 2 + DEPTH));
        checkOutput("t1_words", 64'(xfer_cnt), 64'(DEPTH));

        $display("[TB] reuse 3 and reuse 0");
        clearMarks();
        applyStimulus({$urandom, $urandom}, 8'd3);
        t = pulse_cyc;
        waitIdle();
        checkOutput("r3_words", 64'(xfer_cnt), 64'(3 * DEPTH));
        checkOutput("r3_last_valid", 64'(last_valid_cyc), 64'(t + 2 + 3 * DEPTH));
        clearMarks();
        applyStimulus({$urandom, $urandom}, 8'd0);
        t = pulse_cyc;
        waitIdle();
        checkOutput("r0_words", 64'(xfer_cnt), 64'(DEPTH));
        checkOutput("r0_last_valid", 64'(last_valid_cyc), 64'(t + 2 + DEPTH));

        $display("[TB] backpressure");
        clearMarks();
        bp_en = 1'b1;
        applyStimulus({$urandom, $urandom}, 8'd2);
        waitIdle();
        checkOutput("bp_words", 64'(xfer_cnt), 64'(2 * DEPTH));
        bp_en = 1'b0;

        $display("[TB] ping-pong");
        clearMarks();
        applyStimulus(64'hDEADBEEF_00000000, 8'd1);
        waitWords(100);
        applyStimulus(64'hCAFEBABE_00000000, 8'd1);
        waitIdle();
        checkOutput("pp_sw_count", 64'(sw_cyc_q.size()), 64'(2));
        checkOutput("pp_sw_after_return", 64'(sw_cyc_q[1]), 64'(sw_ren_q[1] + 2));
        checkOutput("pp_gap", 64'(max_gap <= 2), 64'(1));
        checkOutput("pp_words", 64'(xfer_cnt), 64'(2 * DEPTH));

        $display("[TB] pulse in switch cycle");
        clearMarks();
        applyStimulus({$urandom, $urandom}, 8'd1);
        applyStimulus({$urandom, $urandom}, 8'd1);
        waitIdle();
        checkOutput("sim_overflow", 64'(overflow), 64'(0));
        checkOutput("sim_sw_count", 64'(sw_cyc_q.size()), 64'(2));
        checkOutput("sim_words", 64'(xfer_cnt), 64'(2 * DEPTH));

        $display("[TB] overflow");
        clearMarks();
        applyStimulus({$urandom, $urandom}, 8'd1);
        waitWords(50);
        applyStimulus({$urandom, $urandom}, 8'd1);
        applyStimulus({$urandom, $urandom}, 8'd1);
        waitCycles(3);
        applyStimulus({$urandom, $urandom}, 8'd1);
        waitIdle();
        checkOutput("ovf_sticky", 64'(overflow), 64'(1));
        checkOutput("ovf_sw_count", 64'(sw_cyc_q.size()), 64'(2));
        checkOutput("ovf_words", 64'(xfer_cnt), 64'(2 * DEPTH));
        doReset();

        $display("[TB] reset mid-tile");
        applyStimulus({$urandom, $urandom}, 8'd1);
        waitWords(100);
        doReset();
        applyStimulus({$urandom, $urandom}, 8'd1);
        t = pulse_cyc;
        waitIdle();
        checkOutput("mr_first_ren", 64'(first_ren_cyc), 64'(t + 2));
        checkOutput("mr_first_radr", 64'(first_ren_adr), 64'(0));
        checkOutput("mr_words", 64'(xfer_cnt), 64'(DEPTH));

        $display("[TB] random tiles under backpressure");
        bp_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus({$urandom, $urandom}, 8'($urandom_range(0, 3)));
            waitCycles($urandom_range(20, 900));
        end
        waitIdle();
        checkOutput("rnd_queue_empty", 64'(exp_q.size()), 64'(0));
        bp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_db_reader.md
# weight_db_reader

Read-side controller for the weight double buffer. It owns the buffer's `switch_banks`, `ren` and `radr` pins and streams each loaded weight tile (BANK_DEPTH words, optionally replayed several times) to the systolic-array weight loader over a valid/ready interface. It also performs the bank-switch handshake with the weight writer: a bank is swapped only when the writer has finished a tile and the reader has finished the previous one.

## Interface
- DATA_WIDTH, 64, weight word width (matches buffer).
- BANK_ADDR_WIDTH, 10, buffer address width.
- BANK_DEPTH, 288, words per tile (IC0*OC0*FX*FY*IC1).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_tile_done  in  1  one-cycle pulse from the writer: the write bank holds a complete tile.
- wr_bank_free  out  1  the writer may fill the write bank.
- reuse_cnt  in  8  passes per tile; sampled in the switch cycle; 0 is treated as 1.
- switch_banks  out  1  one-cycle pulse to the buffer.
- ren  out  1  buffer read enable.
- radr  out  BANK_ADDR_WIDTH  buffer read address.
- rdata  in  DATA_WIDTH  buffer read data, valid 1 cycle after `ren`.
- out_data  out  DATA_WIDTH  weight word to the loader.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  the loader accepts the word.
- busy  out  1  a tile is being streamed.
- overflow  out  1  sticky error: `wr_tile_done` arrived while a full tile was already pending.

## Operation
- **Flags**
  - `wr_full`: set by `wr_tile_done`; cleared in the switch cycle.
  - `wr_bank_free` = !`wr_full`.
  - If `wr_tile_done` arrives while `wr_full` is already 1, `overflow` sets and the pulse is otherwise ignored.
- **States**
  - **IDLE** -> **SWITCH** when `wr_full`, or when in READ with all reads issued and no read in flight.
  - **SWITCH**: `switch_banks`=1 for exactly one cycle. In this cycle the block also latches passes = max(`reuse_cnt`,1), clears `wr_full`, and resets `radr` and the pass counter. Goes to READ.
  - **READ**: issues reads. When the last address of the last pass has been issued and its data returned:
    - go to SWITCH if `wr_full`;
    - otherwise go to DRAIN if the FIFO is non-empty;
    - otherwise go to IDLE.
  - **DRAIN**: wait for the FIFO to empty, then go to IDLE. If `wr_full` rises during DRAIN, go straight to SWITCH; remaining FIFO words are still delivered in order.
- **Read issue**
  - Output goes through a 2-entry FIFO.
  - `ren`=1 only in READ, and only when (FIFO occupancy + reads in flight) < 2. This guarantees no data loss under backpressure.
  - `radr` counts 0..BANK_DEPTH-1, wraps to 0, and the pass counter increments. No reads are issued after the last pass.
  - `rdata` is pushed into the FIFO in the cycle after `ren`.
- **Output**
  - `out_valid` = FIFO non-empty; `out_data` = FIFO head.
  - A transfer happens when `out_valid`&&`out_ready`.
  - Order: addresses ascending within each pass, passes in sequence.
- `busy` = (state != IDLE) || FIFO non-empty.
- **Simultaneous events**
  - `wr_tile_done` in the same cycle as SWITCH: the clear wins, then the new pulse sets `wr_full` again. The net result is `wr_full`=1 with no overflow.
  - FIFO push and pop in the same cycle: occupancy is unchanged.
- **Reset** (at any point, including mid-tile): state=IDLE, FIFO emptied, in-flight read dropped, `wr_full`=0, `overflow`=0.

## Timing
- Reset values: `switch_banks`=0, `ren`=0, `radr`=0, `out_valid`=0, `out_data`=0, `busy`=0, `overflow`=0, `wr_bank_free`=1.
- `wr_tile_done` at cycle T, block IDLE: `switch_banks`=1 at T+1, first `ren` (`radr`=0) at T+2, first `out_valid` at T+3.
- With `out_ready` held at 1: one word per cycle. A tile of N words with P passes ends its last `out_valid` at T+2+N*P.
- Back-to-back tiles (next `wr_tile_done` already pending): the next `switch_banks` comes in the cycle after the last `rdata` return. The output gap between tiles is at most 2 cycles.
- `out_data` must stay stable while `out_valid`&&!`out_ready`.

## Test plan
- **Single tile:** reset, then pulse `wr_tile_done` with `reuse_cnt`=1; buffer model returns `rdata`=adr.
  - Expect 288 words 0..287 on consecutive cycles.
  - Expect one `switch_banks` pulse at T+1.
  - Expect `busy` to fall after the last word.
- **Reuse:** `reuse_cnt`=3, then `reuse_cnt`=0.
  - With 3: expect 864 words, i.e. 0..287 three times.
  - With 0: expect exactly one pass.
- **Backpressure:** `out_ready` toggles randomly with 50% duty.
  - Expect no word lost or duplicated, `out_data` stable while stalled, and `ren` never issued with 2 words held or in flight.
- **Ping-pong:** a second `wr_tile_done` arrives mid-tile, with the two banks holding 64'hDEADBEEF... and 64'hCAFEBABE....
  - Expect the second switch only after the last read of tile 1 returns.
  - Expect `wr_bank_free` to go 0 and then back to 1 at that switch.
  - Expect tile 2 data to follow tile 1 in order.
- **Overflow:** two `wr_tile_done` pulses while `wr_full`=1 -> `overflow`=1 and held; only one switch occurs.
- **Reset mid-tile:** assert `rst` at word 100 -> the next cycle shows all outputs at their reset values; a fresh `wr_tile_done` then restarts from `radr`=0.
